// File: rtl/dtcm_arb.sv
// rtl/dtcm_arb.sv - two-port DTCM arbiter (core vs ext) with bounded ext starvation
// and one-cycle read return routing.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif

module dtcm_arb #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                     cpu_clk,
  input  logic                     cpu_rstn,
  input  logic                     data_dtcm_access,
  input  logic                     data_dtcm_rd0_wr1,
  input  logic [3:0]               data_dtcm_byte_strobe,
  input  logic [`DATA_WIDTH-1:0]   data_dtcm_write_data,
  input  logic [`ADDR_WIDTH-1:0]   data_dtcm_addr,
  output logic                     data_dtcm_ready,
  output logic [`DATA_WIDTH-1:0]   data_dtcm_read_data,
  output logic                     data_dtcm_read_data_valid,
  input  logic                     ext_dtcm_access,
  input  logic                     ext_dtcm_rd0_wr1,
  input  logic [3:0]               ext_dtcm_byte_strobe,
  input  logic [`DATA_WIDTH-1:0]   ext_dtcm_write_data,
  input  logic [`ADDR_WIDTH-1:0]   ext_dtcm_addr,
  output logic                     ext_dtcm_ready,
  output logic [`DATA_WIDTH-1:0]   ext_dtcm_read_data,
  output logic                     ext_dtcm_read_data_valid,
  output logic                     dtcm_cs,
  output logic                     dtcm_we,
  output logic [3:0]               dtcm_be,
  output logic [`DATA_WIDTH-1:0]   dtcm_wdata,
  output logic [`ADDR_WIDTH-3:0]   dtcm_word_addr,
  input  logic [`DATA_WIDTH-1:0]   dtcm_rdata
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt;
  logic       rd_pend;
  logic       rd_owner;
  logic       grant_ext;
  logic       grant_core;
  logic       granted_read;
  logic       unused_byte_addr;

  // Core has priority unless ext has been denied STARVE_LIMIT cycles in a row.
  always_comb begin
    grant_ext  = ext_dtcm_access && (!data_dtcm_access || (starve_cnt == LIMIT));
    grant_core = data_dtcm_access && !grant_ext;
  end

  assign data_dtcm_ready = grant_core;
  assign ext_dtcm_ready  = grant_ext;

  always_comb begin
    dtcm_cs        = grant_core | grant_ext;
    dtcm_we        = 1'b0;
    dtcm_be        = 4'b0000;
    dtcm_wdata     = data_dtcm_write_data;
    dtcm_word_addr = data_dtcm_addr[`ADDR_WIDTH-1:2];
    if (grant_ext) begin
      dtcm_we        = ext_dtcm_rd0_wr1;
      dtcm_be        = ext_dtcm_byte_strobe;
      dtcm_wdata     = ext_dtcm_write_data;
      dtcm_word_addr = ext_dtcm_addr[`ADDR_WIDTH-1:2];
    end else if (grant_core) begin
      dtcm_we = data_dtcm_rd0_wr1;
      dtcm_be = data_dtcm_byte_strobe;
    end
  end

  assign granted_read     = dtcm_cs && !dtcm_we;
  assign unused_byte_addr = ^{data_dtcm_addr[1:0], ext_dtcm_addr[1:0]};

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      starve_cnt <= 4'd0;
      rd_pend    <= 1'b0;
      rd_owner   <= 1'b0;
    end else begin
      if (!ext_dtcm_access || grant_ext) begin
        starve_cnt <= 4'd0;
      end else if (starve_cnt != LIMIT) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
      rd_pend <= granted_read;
      if (granted_read) begin
        rd_owner <= grant_ext;
      end
    end
  end

  // SRAM data is shared; each requester sees it only through its own valid.
  assign data_dtcm_read_data       = dtcm_rdata;
  assign ext_dtcm_read_data        = dtcm_rdata;
  assign data_dtcm_read_data_valid = rd_pend & ~rd_owner;
  assign ext_dtcm_read_data_valid  = rd_pend & rd_owner;

endmodule

// File: doc/dtcm_arb.md
DTCM_ARB -- requirements
Module: dtcm_arb

Interface
REQ-001 The block SHALL declare parameter STARVE_LIMIT, default 4: the number of consecutive cycles the ext port may be denied while requesting before it is forced to win; legal range 1..15.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset, with ports as follows.
REQ-003 cpu_clk  input  1  CPU clock; all state is updated on the rising edge.
REQ-004 cpu_rstn  input  1  asynchronous active-low reset.
REQ-005 data_dtcm_access  input  1  core requests a DTCM access this cycle.
REQ-006 data_dtcm_rd0_wr1  input  1  core command: 0 = read, 1 = write.
REQ-007 data_dtcm_byte_strobe  input  4  core byte strobe.
REQ-008 data_dtcm_write_data  input  `DATA_WIDTH  core write data.
REQ-009 data_dtcm_addr  input  `ADDR_WIDTH  core DTCM-relative byte address.
REQ-010 data_dtcm_ready  output  1  core command accepted this cycle.
REQ-011 data_dtcm_read_data  output  `DATA_WIDTH  core read data.
REQ-012 data_dtcm_read_data_valid  output  1  core read data valid.
REQ-013 ext_dtcm_access, ext_dtcm_rd0_wr1, ext_dtcm_byte_strobe, ext_dtcm_write_data, ext_dtcm_addr  inputs  1/1/4/`DATA_WIDTH/`ADDR_WIDTH  the same request fields for the external (AHB slave/debug) requester.
REQ-014 ext_dtcm_ready, ext_dtcm_read_data, ext_dtcm_read_data_valid  outputs  1/`DATA_WIDTH/1  the same response fields for the ext requester.
REQ-015 dtcm_cs  output  1  SRAM chip select.
REQ-016 dtcm_we  output  1  SRAM write enable.
REQ-017 dtcm_be  output  4  SRAM byte enables.
REQ-018 dtcm_wdata  output  `DATA_WIDTH  SRAM write data.
REQ-019 dtcm_word_addr  output  `ADDR_WIDTH-2  SRAM word address, equal to addr[`ADDR_WIDTH-1:2].
REQ-020 dtcm_rdata  input  `DATA_WIDTH  SRAM read data, valid exactly one cycle after a read with cs=1.

Function
REQ-021 Arbitration SHALL be combinational within the cycle, using this grant rule:
- grant_ext = ext_access && (!core_access || starve_cnt == STARVE_LIMIT).
- grant_core = core_access && !grant_ext.
REQ-022 data_dtcm_ready SHALL equal grant_core and ext_dtcm_ready SHALL equal grant_ext; no requester is ever readied in a cycle it does not request.
REQ-023 Each requester SHALL hold its request fields stable until its ready is sampled high; the arbiter SHALL NOT buffer commands.
REQ-024 The SRAM outputs SHALL be driven from the granted requester:
- dtcm_cs = grant_core | grant_ext.
- dtcm_we = granted rd0_wr1 & cs.
- dtcm_be = granted byte strobe, or 4'b0000 when cs=0.
REQ-025 starve_cnt (4 bits) SHALL behave as follows on each clock edge:
- cleared to 0 when ext is granted or ext is not requesting;
- otherwise incremented, saturating at STARVE_LIMIT.
REQ-026 Read return SHALL use a one-entry pipeline: on a granted read, rd_pend <= 1 and rd_owner <= grant_ext; otherwise rd_pend <= 0.
REQ-027 The read response SHALL be routed by the pipeline state:
- core_read_data_valid = rd_pend & !rd_owner.
- ext_read_data_valid = rd_pend & rd_owner.
- Both read_data outputs = dtcm_rdata, the value being qualified only by its valid.
REQ-028 Read latency SHALL be exactly one cycle after ready; back-to-back reads, including reads alternating between owners, SHALL sustain one access per cycle.
REQ-029 Writes SHALL complete in the grant cycle and SHALL NOT produce a read_data_valid pulse.
REQ-030 When both ports address the same word in the same cycle, only the granted port's access SHALL take effect; the loser retries on a later cycle.

Reset
REQ-031 While cpu_rstn = 0, the block SHALL hold starve_cnt = 0, rd_pend = 0 and rd_owner = 0, which forces both read_data_valid outputs to 0.
REQ-032 An assertion of cpu_rstn in the cycle after a granted read SHALL suppress that read's valid pulse, and no stale valid SHALL appear after reset release.
REQ-033 The ready and dtcm_* outputs SHALL remain combinational functions of the requests, with reset affecting them only through starve_cnt.

Verification
REQ-034 Core-only read of addr 0x10 with SRAM word 4 = 0xDEADBEEF -> data_dtcm_ready=1 in cycle N; data_dtcm_read_data_valid=1 with 0xDEADBEEF in cycle N+1; ext valid stays 0.
REQ-035 Core and ext requesting continuously, STARVE_LIMIT=4 -> core granted on 4 cycles, ext granted on the 5th, and the pattern repeats; starve_cnt sequence is 1,2,3,4,0.
REQ-036 Alternating reads (core addr 0x0, ext addr 0x4, core addr 0x8) on consecutive cycles -> valids alternate core/ext/core on consecutive cycles with the matching SRAM words, and no cycle is lost.
REQ-037 Ext write 0x12345678 with be=4'b0011 at addr 0x20, then core read of 0x20 -> dtcm_we=1, dtcm_be=4'b0011, dtcm_word_addr=8; no valid pulse on the write; the read returns the SRAM content.
REQ-038 Core read granted in cycle N with cpu_rstn driven low during N+1 -> no read_data_valid in N+1; after release, starve_cnt=0 and both valids stay 0 until the next granted read.
